div_unit: RTL

Iterative multi-cycle integer divider for the single-cycle datapath. It accepts a dividend/divisor pair from the execute stage, runs a radix-2 restoring division, and returns quotient and remainder. It drives `divIsActive`, the stall input of the PC update stage, so the PC holds for the entire division.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 36 +++
 rtl/div_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// The optional signed mode is enabled by the DIV_SIGNED_EN macro and
// lives in div_unit.sv; this package is the same in both builds.
package div_pkg;

    // Default operand / quotient / remainder width.
    localparam int DIV_WIDTH = 32;

    // Iteration counter width: counts WIDTH-1 down to 0.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The partial remainder is shifted left with the next dividend bit.
// The divisor magnitude is then trial-subtracted. A non-negative
// difference is kept and yields quotient bit 1. Otherwise the shifted
// value is restored and the quotient bit is 0. The trial is computed
// one bit wider than the partial remainder, so its sign bit is a
// reliable borrow indicator.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH:0]   new_rem,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Shift, trial-subtract, then keep or restore.
    always_comb begin
        shifted_s = {part_rem, next_bit};
        diff_s    = shifted_s - {2'b00, dvs_mag};
        if (diff_s[WIDTH+1] == 1'b0) begin
            new_rem = diff_s[WIDTH:0];
            q_bit   = 1'b1;
        end else begin
            new_rem = shifted_s[WIDTH:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative multi-cycle integer divider (radix-2 restoring).
// It takes WIDTH BUSY cycles per division, and divide-by-zero
// completes in one cycle. divIsActive stalls the PC update stage
// while a division is accepted or running.
// Optional feature: define DIV_SIGNED_EN to honour isSigned. This adds
// magnitude conversion on entry and sign fix-up on exit. Without it,
// every division is unsigned and no negation logic exists.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             divIsActive
);

    localparam int CNT_W = $clog2(WIDTH);

    // Control state and iteration counter.
    div_state_t       state_r;
    logic [CNT_W-1:0] count_r;

    // Working registers.
    // work_r shifts dividend bits out at the top.
    // Quotient bits shift in at the bottom.
    logic [WIDTH:0]   prem_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] dvs_r;

    // Registered results.
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             done_r;

    // Combinational helpers.
    logic             accept_s;
    logic             div_zero_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH:0]   step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] raw_q_s;
    logic [WIDTH-1:0] raw_r_s;
    logic [WIDTH-1:0] fin_q_s;
    logic [WIDTH-1:0] fin_r_s;

`ifdef DIV_SIGNED_EN
    logic             neg_dvd_s;
    logic             neg_dvs_s;
    logic             neg_q_r;
    logic             neg_r_r;
`else
    // isSigned has no function in the unsigned-only build.
    logic             sign_unused_s;
    assign sign_unused_s = isSigned;
`endif

    // A request is taken only when no division is running.
    always_comb begin
        accept_s = 1'b0;
        if (start && ((state_r == IDLE) || (state_r == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign div_zero_s = (divisor == {WIDTH{1'b0}});

    // Stall PC update for the accept cycle and every BUSY cycle.
    // The stall is suppressed while reset is asserted.
    assign divIsActive = reset_n & (accept_s | (state_r == BUSY));

`ifdef DIV_SIGNED_EN
    // Operand magnitudes and sign flags for a signed request.
    // |-2^(WIDTH-1)| still fits because magnitudes are unsigned.
    always_comb begin
        neg_dvd_s = isSigned & dividend[WIDTH-1];
        neg_dvs_s = isSigned & divisor[WIDTH-1];
        dvd_mag_s = neg_dvd_s ? ((~dividend) + WIDTH'(1)) : dividend;
        dvs_mag_s = neg_dvs_s ? ((~divisor) + WIDTH'(1)) : divisor;
    end
`else
    // Unsigned-only build: operands are already magnitudes.
    always_comb begin
        dvd_mag_s = dividend;
        dvs_mag_s = divisor;
    end
`endif

    // The single shared iteration datapath, reused every BUSY cycle.
    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .part_rem (prem_r),
        .next_bit (work_r[WIDTH-1]),
        .dvs_mag  (dvs_r),
        .new_rem  (step_rem_s),
        .q_bit    (step_q_s)
    );

    assign raw_q_s = {work_r[WIDTH-2:0], step_q_s};
    assign raw_r_s = step_rem_s[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    // Final sign fix-up.
    // The quotient is negated when the operand signs differ.
    // The remainder follows the dividend's sign.
    always_comb begin
        fin_q_s = neg_q_r ? ((~raw_q_s) + WIDTH'(1)) : raw_q_s;
        fin_r_s = neg_r_r ? ((~raw_r_s) + WIDTH'(1)) : raw_r_s;
    end
`else
    // Unsigned-only build: the raw iteration result is final.
    always_comb begin
        fin_q_s = raw_q_s;
        fin_r_s = raw_r_s;
    end
`endif

    // Divider FSM: accept, iterate, and register results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            prem_r      <= {(WIDTH+1){1'b0}};
            work_r      <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            done_r      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        if (div_zero_s) begin
                            // Divide-by-zero finishes next cycle.
                            // The raw dividend is returned as the remainder.
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            prem_r  <= {(WIDTH+1){1'b0}};
                            work_r  <= dvd_mag_s;
                            dvs_r   <= dvs_mag_s;
                            count_r <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                            neg_q_r <= neg_dvd_s ^ neg_dvs_s;
                            neg_r_r <= neg_dvd_s;
`endif
                            done_r  <= 1'b0;
                            state_r <= BUSY;
                        end
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    prem_r <= step_rem_s;
                    work_r <= raw_q_s;
                    if (count_r == {CNT_W{1'b0}}) begin
                        quotient_r  <= fin_q_s;
                        remainder_r <= fin_r_s;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                        done_r  <= 1'b0;
                        state_r <= BUSY;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign done      = done_r;

endmodule
